// File: rtl/bdi_decompressor_pipe.sv
// bdi_decompressor_pipe: two-stage Base-Delta-Immediate line decompressor for one packed cache slot.
// Optional perf counters (perf_lines/perf_errors) are built when BDI_DECOMP_PERF_EN is defined.
module bdi_decompressor_pipe #(
  parameter int NUM_LINES = 2,
  parameter int WORD_WIDTH = 32,
  localparam int SEL_W = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1,
  localparam int LINE_BYTES = WORD_WIDTH,
  localparam int DW = 8 * WORD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  input  logic [4*NUM_LINES-1:0]  in_mode,
  input  logic [16*NUM_LINES-1:0] in_base_one_hot,
  input  logic [NUM_LINES-1:0]    in_line_valid,
  input  logic [SEL_W-1:0]        in_select,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
`ifdef BDI_DECOMP_PERF_EN
  output logic [31:0]             perf_lines,
  output logic [31:0]             perf_errors,
`endif
  output logic                    out_error
);
  function automatic logic [8:0] seg_size(input logic [3:0] m);
    case (m)
      4'd0: return 9'd4;
      4'd1: return 9'd8;
      4'd2: return 9'd12;
      4'd3: return 9'd16;
      4'd4: return 9'd24;
      4'd5: return 9'd12;
      4'd6: return 9'd20;
      4'd7: return 9'd18;
      4'd15: return 9'd32;
      default: return 9'd0;
    endcase
  endfunction
  // x-byte base followed by y-byte signed deltas, one per x-byte element
  function automatic logic [DW-1:0] bxdy(input logic [DW-1:0] seg, input int x, input int y,
                                         input logic [15:0] oh);
    logic [DW-1:0] res, t;
    logic [63:0] base, d, e;
    res = '0;
    base = x == 2 ? {48'd0, seg[15:0]} : x == 4 ? {32'd0, seg[31:0]} : seg[63:0];
    for (int i = 0; i < 16; i++) begin
      t = seg >> (8 * (x + i * y));
      d = y == 1 ? {{56{t[7]}}, t[7:0]} : y == 2 ? {{48{t[15]}}, t[15:0]} : {{32{t[31]}}, t[31:0]};
      e = (oh[i] ? base : 64'd0) + d;
      for (int b = 0; b < 8; b++)
        if (i < LINE_BYTES / x && b < x) res[8 * ((i * x + b) % LINE_BYTES) +: 8] = e[8 * b +: 8];
    end
    return res;
  endfunction
  logic s1_valid, s2_adv, err, others, sel_lv, s1_err;
  logic [3:0] sel_mode, s1_mode;
  logic [15:0] sel_oh, s1_oh;
  logic [8:0] off, s1_off;
  logic [DW-1:0] s1_data, seg, rpv4, rpv8, exp_d;
  assign s2_adv = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  always_comb begin
    sel_mode = '0;
    sel_oh = '0;
    sel_lv = 1'b0;
    off = '0;
    for (int j = 0; j < NUM_LINES; j++) begin
      if (j == int'(in_select)) begin
        sel_mode = in_mode[4*j +: 4];
        sel_oh = in_base_one_hot[16*j +: 16];
        sel_lv = in_line_valid[j];
      end
      if (j < int'(in_select) && in_line_valid[j]) off = off + seg_size(in_mode[4*j +: 4]);
    end
    others = |(in_line_valid & ~(NUM_LINES'(1) << in_select));
    err = !sel_lv || (sel_mode[3] && sel_mode != 4'hF) || (off + seg_size(sel_mode) > 9'(LINE_BYTES))
          || (sel_mode == 4'hF && others);
  end
  always_comb begin
    seg = s1_data >> {s1_off, 3'b000};
    rpv4 = '0;
    rpv8 = '0;
    for (int i = 0; i < LINE_BYTES / 4; i++) rpv4[32*i +: 32] = seg[31:0];
    for (int i = 0; i < LINE_BYTES / 8; i++) rpv8[64*i +: 64] = seg[63:0];
    case (s1_mode)
      4'd0: exp_d = rpv4;
      4'd1: exp_d = rpv8;
      4'd2: exp_d = bxdy(seg, 8, 1, s1_oh);
      4'd3: exp_d = bxdy(seg, 8, 2, s1_oh);
      4'd4: exp_d = bxdy(seg, 8, 4, s1_oh);
      4'd5: exp_d = bxdy(seg, 4, 1, s1_oh);
      4'd6: exp_d = bxdy(seg, 4, 2, s1_oh);
      4'd7: exp_d = bxdy(seg, 2, 1, s1_oh);
      default: exp_d = s1_data;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      out_data <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        out_data <= s1_err ? '0 : exp_d;
        out_error <= s1_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_off <= off;
      s1_mode <= sel_mode;
      s1_oh <= sel_oh;
      s1_err <= err;
      s1_data <= in_data;
    end
  end
`ifdef BDI_DECOMP_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lines <= '0;
      perf_errors <= '0;
    end else if (out_valid && out_ready) begin
      if (out_error && perf_errors != '1) perf_errors <= perf_errors + 32'd1;
      if (!out_error && perf_lines != '1) perf_lines <= perf_lines + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bdi_decompressor_pipe.sv
// tb_bdi_decompressor_pipe: scoreboard bench with a byte-level reference model of BDI expansion.
module tb_bdi_decompressor_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, out_error;
  logic [255:0] in_data = '0, out_data;
  logic [7:0] in_mode = '0;
  logic [31:0] in_oh = '0;
  logic [1:0] in_lv = '0;
  logic in_select = 0;
  bdi_decompressor_pipe #(.NUM_LINES(2), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_base_one_hot(in_oh), .in_line_valid(in_lv), .in_select(in_select),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_error(out_error));
  always #5 clk = ~clk;
  typedef struct {logic [255:0] d; logic e; int c; bit l;} exp_t;
  exp_t q[$];
  exp_t ex;
  int checks = 0, passed = 0, cyc = 0, rmode = 0, pi = 0;
  bit lat_chk = 0, held_v = 0;
  logic [255:0] cur_d, held_d, rd;
  logic cur_e, held_e;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  function automatic int sz(input logic [3:0] m);
    case (m)
      0: return 4;
      1: return 8;
      2: return 12;
      3: return 16;
      4: return 24;
      5: return 12;
      6: return 20;
      7: return 18;
      15: return 32;
      default: return -1;
    endcase
  endfunction
  task automatic model(input logic [255:0] d, input logic [7:0] m, input logic [31:0] oh,
                       input logic [1:0] lv, input logic s, output logic [255:0] r, output logic e);
    byte unsigned b[32];
    int off, ms, x, y;
    logic [3:0] mm;
    logic [15:0] o;
    longint base, dv, v;
    r = '0;
    mm = m[4*s +: 4];
    o = oh[16*s +: 16];
    off = (s == 1'b1 && lv[0]) ? sz(m[3:0]) : 0;
    ms = sz(mm);
    e = !lv[s] || ms < 0 || off + ms > 32 || (mm == 4'hF && lv[!s]);
    if (e) return;
    for (int k = 0; k < 32; k++) b[k] = (off + k < 32) ? d[8*(off+k) +: 8] : 8'd0;
    if (mm == 4'hF) r = d;
    else if (mm == 0) for (int i = 0; i < 32; i++) r[8*i +: 8] = b[i % 4];
    else if (mm == 1) for (int i = 0; i < 32; i++) r[8*i +: 8] = b[i % 8];
    else begin
      x = mm <= 4 ? 8 : mm <= 6 ? 4 : 2;
      y = (mm == 2 || mm == 5 || mm == 7) ? 1 : (mm == 3 || mm == 6) ? 2 : 4;
      base = 0;
      for (int k = 0; k < x; k++) base |= longint'(b[k]) << (8 * k);
      for (int i = 0; i < 32 / x; i++) begin
        dv = 0;
        for (int k = 0; k < y; k++) dv |= longint'(b[x + i*y + k]) << (8 * k);
        if (b[x + i*y + y - 1] >= 128) dv -= longint'(1) << (8 * y);
        v = (o[i] ? base : 64'd0) + dv;
        for (int k = 0; k < x; k++) r[8*(i*x + k) +: 8] = v[8*k +: 8];
      end
    end
  endtask
  function automatic logic [255:0] rnd256();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
    return t;
  endfunction
  task automatic send(input logic [255:0] d, input logic [7:0] m, input logic [31:0] oh,
                      input logic [1:0] lv, input logic s, input bit lit, input logic [255:0] ld,
                      input logic le);
    logic [255:0] md;
    logic me;
    int n;
    model(d, m, oh, lv, s, md, me);
    in_data = d;
    in_mode = m;
    in_oh = oh;
    in_lv = lv;
    in_select = s;
    cur_d = lit ? ld : md;
    cur_e = lit ? le : me;
    in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles want 1", n);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic rand_req();
    logic [3:0] m0, m1;
    logic s;
    int p;
    s = 1'($urandom_range(0, 1));
    p = $urandom_range(0, 9);
    m0 = p < 8 ? 4'(p) : 4'hF;
    p = $urandom_range(0, 9);
    m1 = p < 8 ? 4'(p) : 4'hF;
    if ($urandom_range(0, 9) == 0) begin
      if (s) m1 = 4'(8 + $urandom_range(0, 6));
      else m0 = 4'(8 + $urandom_range(0, 6));
    end
    send(rnd256(), {m1, m0}, $urandom, 2'($urandom_range(0, 3)), s, 0, '0, 0);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      n++;
      @(posedge clk);
    end
    #1 chk("drain_empty", 256'(q.size()), 256'd0);
  endtask
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1;
      1: out_ready = $urandom_range(0, 2) != 0;
      2: begin
        out_ready = (pi % 4 == 0) || (pi % 4 == 3);
        pi++;
      end
      default: out_ready = 0;
    endcase
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held_v = 0;
    end else begin
      if (out_valid && held_v) begin
        chk("stall_data", out_data, held_d);
        chk("stall_err", 256'(out_error), 256'(held_e));
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_e = out_error;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got data %h want no output", out_data);
        end else begin
          ex = q.pop_front();
          chk("out_data", out_data, ex.d);
          chk("out_error", 256'(out_error), 256'(ex.e));
          if (ex.l) chk("latency", 256'(cyc - ex.c), 256'd2);
        end
      end
      if (in_valid && in_ready) q.push_back('{cur_d, cur_e, cyc, lat_chk});
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_out_error", 256'(out_error), 256'd0);
    chk("rst_out_data", out_data, 256'd0);
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    lat_chk = 1;
    send({128'd0, 32'h0002FF01, 64'h1000, 32'hDEADBEEF}, 8'h20, 32'h000F0000, 2'b11, 1'b1, 1,
         {64'h1000, 64'h1002, 64'h0FFF, 64'h1001}, 0);
    send({112'd0, {16{8'h7F}}, 16'h8000}, 8'h07, 32'h000000FF, 2'b01, 1'b0, 1,
         {{8{16'h007F}}, {8{16'h807F}}}, 0);
    send(rnd256(), 8'h54, 32'hFFFFFFFF, 2'b11, 1'b1, 1, '0, 1);
    send(rnd256(), 8'h0F, 32'h0, 2'b11, 1'b0, 1, '0, 1);
    rd = rnd256();
    send(rd, 8'h0F, 32'h0, 2'b01, 1'b0, 1, rd, 0);
    send(rnd256(), 8'h10, 32'h0, 2'b01, 1'b1, 1, '0, 1);
    send(rnd256(), 8'h09, 32'h0, 2'b01, 1'b0, 1, '0, 1);
    drain();
    lat_chk = 0;
    @(negedge clk);
    pi = 0;
    rmode = 2;
    @(posedge clk);
    #1;
    repeat (8) rand_req();
    rmode = 0;
    drain();
    rmode = 3;
    send(rnd256(), 8'h10, 32'h1, 2'b11, 1'b1, 0, '0, 0);
    send(rnd256(), 8'h00, 32'h1, 2'b01, 1'b0, 0, '0, 0);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    rmode = 0;
    chk("flush_out_valid", 256'(out_valid), 256'd0);
    chk("flush_in_ready", 256'(in_ready), 256'd1);
    repeat (6) @(posedge clk);
    #1 chk("no_stale_output", 256'(out_valid), 256'd0);
    rmode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      rand_req();
    end
    rmode = 0;
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
